// File: rtl/mac_obuf_deskew.sv
// mac_obuf_deskew: collects the skewed per-row psum streams of the 4x4 MAC
// array, re-aligns them into whole result vectors in a two-bank ping-pong
// tile buffer, and drains completed tiles through a valid/ready stream.
module mac_obuf_deskew #(
    parameter int DEPTH = 4,
    parameter int DW    = 16
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic [4*DW-1:0]   ODATA_IN,
    input  logic [3:0]        OVALID_IN,
    output logic [4*DW-1:0]   M_DATA,
    output logic              M_VALID,
    input  logic              M_READY,
    output logic              M_LAST,
    input  logic              CLR_ERR,
    output logic              OVF_ERR,
    output logic              BUSY
);

    // Write counters run 0..DEPTH (DEPTH means "row done"), read counter 0..DEPTH-1.
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] WCNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] WCNT_ONE  = CW'(1);
    localparam logic [AW-1:0] RCNT_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] RCNT_ONE  = AW'(1);

    // Architectural state
    logic              wbank_r;
    logic              rbank_r;
    logic [CW-1:0]     wcnt_r [4];
    logic [AW-1:0]     rcnt_r;
    logic [1:0]        full_r;
    logic              ovf_r;
    logic [DW-1:0]     mem_r [2][4][DEPTH];

    // Write-side decode
    logic [DW-1:0]     row_data_s [4];
    logic [3:0]        acc_s;
    logic [3:0]        drop_s;
    logic [CW-1:0]     wcnt_nxt_s [4];
    logic              tile_done_s;

    // Read-side decode
    logic              fire_s;
    logic              last_beat_s;
    logic [1:0]        full_nxt_s;

    // Split the packed input into rows and decide per row: accept, drop or idle.
    always_comb begin
        tile_done_s = 1'b1;
        for (int r = 0; r < 4; r++) begin
            row_data_s[r] = ODATA_IN[(4*DW-1)-r*DW -: DW];
            if (OVALID_IN[r] && !full_r[wbank_r] && (wcnt_r[r] != WCNT_FULL)) begin
                acc_s[r] = 1'b1;
            end else begin
                acc_s[r] = 1'b0;
            end
            drop_s[r] = OVALID_IN[r] & ~acc_s[r];
            if (acc_s[r]) begin
                wcnt_nxt_s[r] = wcnt_r[r] + WCNT_ONE;
            end else begin
                wcnt_nxt_s[r] = wcnt_r[r];
            end
            if (wcnt_nxt_s[r] != WCNT_FULL) begin
                tile_done_s = 1'b0;
            end else begin
                tile_done_s = tile_done_s;
            end
        end
    end

    // Beat handshake and combined bank-full update (fill on one bank, free on the other).
    always_comb begin
        fire_s      = full_r[rbank_r] & M_READY;
        last_beat_s = fire_s && (rcnt_r == RCNT_LAST);
        full_nxt_s  = full_r;
        if (last_beat_s) begin
            full_nxt_s[rbank_r] = 1'b0;
        end else begin
            full_nxt_s[rbank_r] = full_r[rbank_r];
        end
        // A completing tile always targets a non-full bank, so it never collides with the freed one.
        if (tile_done_s) begin
            full_nxt_s[wbank_r] = 1'b1;
        end else begin
            full_nxt_s[wbank_r] = full_nxt_s[wbank_r];
        end
    end

    // Control state: bank pointers, fill/drain counters, full flags and sticky error.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            wbank_r <= 1'b0;
            rbank_r <= 1'b0;
            rcnt_r  <= {AW{1'b0}};
            full_r  <= 2'b00;
            ovf_r   <= 1'b0;
            for (int r = 0; r < 4; r++) begin
                wcnt_r[r] <= {CW{1'b0}};
            end
        end else begin
            full_r <= full_nxt_s;
            if (tile_done_s) begin
                wbank_r <= ~wbank_r;
                for (int r = 0; r < 4; r++) begin
                    wcnt_r[r] <= {CW{1'b0}};
                end
            end else begin
                for (int r = 0; r < 4; r++) begin
                    wcnt_r[r] <= wcnt_nxt_s[r];
                end
            end
            if (last_beat_s) begin
                rcnt_r  <= {AW{1'b0}};
                rbank_r <= ~rbank_r;
            end else if (fire_s) begin
                rcnt_r  <= rcnt_r + RCNT_ONE;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (|drop_s) begin
                ovf_r <= 1'b1;
            end else if (CLR_ERR) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Tile storage: each accepted psum lands at its row's own fill position.
    always_ff @(posedge CLK) begin
        for (int r = 0; r < 4; r++) begin
            if (acc_s[r]) begin
                mem_r[wbank_r][r][wcnt_r[r][AW-1:0]] <= row_data_s[r];
            end
        end
    end

    // Output stream is a direct view of the read bank; data is forced to zero when idle.
    always_comb begin
        M_VALID = full_r[rbank_r];
        if (M_VALID) begin
            M_DATA = {mem_r[rbank_r][0][rcnt_r], mem_r[rbank_r][1][rcnt_r],
                      mem_r[rbank_r][2][rcnt_r], mem_r[rbank_r][3][rcnt_r]};
            M_LAST = (rcnt_r == RCNT_LAST);
        end else begin
            M_DATA = {(4*DW){1'b0}};
            M_LAST = 1'b0;
        end
    end

    // Status flags: sticky overflow and busy whenever anything is buffered.
    always_comb begin
        OVF_ERR = ovf_r;
        BUSY    = |full_r;
        for (int r = 0; r < 4; r++) begin
            if (wcnt_r[r] != {CW{1'b0}}) begin
                BUSY = 1'b1;
            end else begin
                BUSY = BUSY;
            end
        end
    end

endmodule

// File: tb/tb_mac_obuf_deskew.sv
// Self-checking bench for mac_obuf_deskew: directed scenarios plus randomized
// traffic, all compared every cycle against a queue-based behavioural model.
module tb_mac_obuf_deskew;

    localparam int DEPTH = 4;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic [63:0]   odata;
    logic [3:0]    ovalid;
    logic [63:0]   m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          clr_err;
    logic          ovf_err;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Behavioural model: per-row collection lists, a flat queue of completed
    // beats, the number of complete tiles held (at most two) and the beat position.
    int            rcount [4];
    logic [15:0]   rdat [4][DEPTH];
    logic [63:0]   bq [$];
    int            ntiles;
    int            beat;
    logic          ovf_m;

    always #5 clk = ~clk;

    mac_obuf_deskew #(.DEPTH(DEPTH), .DW(DW)) dut (
        .CLK(clk), .RSTN(rstn), .ODATA_IN(odata), .OVALID_IN(ovalid),
        .M_DATA(m_data), .M_VALID(m_valid), .M_READY(m_ready), .M_LAST(m_last),
        .CLR_ERR(clr_err), .OVF_ERR(ovf_err), .BUSY(busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 4; r++) rcount[r] = 0;
        bq.delete();
        ntiles = 0;
        beat   = 0;
        ovf_m  = 1'b0;
    endtask

    // One clock edge of the model, using the inputs that the DUT saw at that edge.
    task automatic model_step();
        logic wfull;
        logic dropped;
        logic fire;
        logic done;
        if (!rstn) begin
            model_reset();
            return;
        end
        // With two banks, the write target is full exactly when two tiles are held.
        wfull   = (ntiles == 2);
        fire    = (ntiles > 0) && m_ready;
        dropped = 1'b0;
        for (int r = 0; r < 4; r++) begin
            if (ovalid[r]) begin
                if (wfull || rcount[r] == DEPTH) begin
                    dropped = 1'b1;
                end else begin
                    rdat[r][rcount[r]] = odata[63-16*r -: 16];
                    rcount[r]++;
                end
            end
        end
        if (dropped) ovf_m = 1'b1;
        else if (clr_err) ovf_m = 1'b0;
        if (fire) begin
            void'(bq.pop_front());
            if (beat == DEPTH - 1) begin
                beat = 0;
                ntiles--;
            end else begin
                beat++;
            end
        end
        done = 1'b1;
        for (int r = 0; r < 4; r++) if (rcount[r] != DEPTH) done = 1'b0;
        if (done) begin
            for (int k = 0; k < DEPTH; k++)
                bq.push_back({rdat[0][k], rdat[1][k], rdat[2][k], rdat[3][k]});
            for (int r = 0; r < 4; r++) rcount[r] = 0;
            ntiles++;
        end
    endtask

    task automatic compare();
        logic        ev;
        logic [63:0] ed;
        logic        eb;
        ev = (ntiles > 0);
        ed = ev ? bq[0] : 64'h0;
        eb = (ntiles > 0);
        for (int r = 0; r < 4; r++) if (rcount[r] != 0) eb = 1'b1;
        chk("m_valid", {63'h0, m_valid}, {63'h0, ev});
        chk("m_data",  m_data, ed);
        chk("m_last",  {63'h0, m_last}, {63'h0, ev && (beat == DEPTH - 1)});
        chk("ovf_err", {63'h0, ovf_err}, {63'h0, ovf_m});
        chk("busy",    {63'h0, busy}, {63'h0, eb});
    endtask

    // Advance one clock: inputs are held across the edge, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        compare();
    endtask

    // Skewed tile: row r pulses at cycles r..r+3, k-th psum = base + (r<<8) + k.
    task automatic fill_skew(input logic [15:0] base);
        for (int c = 0; c < DEPTH + 3; c++) begin
            ovalid = 4'b0000;
            for (int r = 0; r < 4; r++) begin
                if (c >= r && c <= r + DEPTH - 1) begin
                    ovalid[r] = 1'b1;
                    odata[63-16*r -: 16] = base + 16'(r * 256) + 16'(c - r);
                end
            end
            tick();
        end
        ovalid = 4'b0000;
    endtask

    initial begin
        rstn    = 1'b0;
        odata   = 64'h0;
        ovalid  = 4'b0000;
        m_ready = 1'b0;
        clr_err = 1'b0;
        model_reset();
        tick();
        tick();
        chk("reset_valid", {63'h0, m_valid}, 64'h0);
        chk("reset_busy",  {63'h0, busy}, 64'h0);
        rstn = 1'b1;

        // 1: skewed tile, free-running drain
        m_ready = 1'b1;
        fill_skew(16'h0000);
        chk("t1_beat0_lit", m_data, 64'h0000_0100_0200_0300);
        chk("t1_model_pin", bq[0], 64'h0000_0100_0200_0300);
        chk("t1_valid_lit", {63'h0, m_valid}, 64'h1);
        tick();
        tick();
        tick();
        chk("t1_beat3_lit", m_data, 64'h0003_0103_0203_0303);
        chk("t1_last_lit",  {63'h0, m_last}, 64'h1);
        tick();
        chk("t1_drained", {63'h0, m_valid}, 64'h0);
        chk("t1_ovf_lit", {63'h0, ovf_err}, 64'h0);

        // 2: backpressure holds the first beat stable
        m_ready = 1'b0;
        fill_skew(16'h0000);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_lit", m_data, 64'h0000_0100_0200_0300);
            tick();
        end
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();

        // 3: both banks full, extra psum dropped, then A and B drain intact
        m_ready = 1'b0;
        fill_skew(16'h0000);
        fill_skew(16'h0040);
        ovalid = 4'b0001;
        odata[63:48] = 16'hDEAD;
        tick();
        ovalid = 4'b0000;
        chk("t3_ovf_lit", {63'h0, ovf_err}, 64'h1);
        m_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            tick();
            chk("t3_no_dead", {63'h0, m_data[63:48] == 16'hDEAD}, 64'h0);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;

        // 4: row0 overrun while the other rows lag
        for (int k = 0; k <= DEPTH; k++) begin
            ovalid = 4'b0001;
            odata[63:48] = (k == DEPTH) ? 16'hBEEF : 16'(k);
            tick();
        end
        chk("t4_ovf_lit", {63'h0, ovf_err}, 64'h1);
        for (int k = 0; k < DEPTH; k++) begin
            ovalid = 4'b1110;
            odata[47:0] = {16'h0100 + 16'(k), 16'h0200 + 16'(k), 16'h0300 + 16'(k)};
            tick();
        end
        ovalid = 4'b0000;
        chk("t4_beat0_lit", m_data, 64'h0000_0100_0200_0300);
        for (int i = 0; i < DEPTH + 1; i++) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;

        // 5: reset in the middle of a drain
        m_ready = 1'b0;
        fill_skew(16'h0000);
        m_ready = 1'b1;
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("t5_valid_lit", {63'h0, m_valid}, 64'h0);
        chk("t5_busy_lit",  {63'h0, busy}, 64'h0);
        chk("t5_ovf_lit",   {63'h0, ovf_err}, 64'h0);
        fill_skew(16'h0080);
        chk("t5_beat0_lit", m_data, 64'h0080_0180_0280_0380);
        for (int i = 0; i < DEPTH + 1; i++) tick();

        // 6: clear loses against a simultaneous drop, then clears alone
        for (int k = 0; k < DEPTH; k++) begin
            ovalid = 4'b0001;
            odata[63:48] = 16'(k);
            tick();
        end
        ovalid  = 4'b0001;
        clr_err = 1'b1;
        tick();
        chk("t6_set_wins", {63'h0, ovf_err}, 64'h1);
        ovalid = 4'b0000;
        tick();
        clr_err = 1'b0;
        chk("t6_cleared", {63'h0, ovf_err}, 64'h0);
        for (int k = 0; k < DEPTH; k++) begin
            ovalid = 4'b1110;
            tick();
        end
        ovalid = 4'b0000;
        for (int i = 0; i < DEPTH + 1; i++) tick();

        // Randomized traffic with varying density, backpressure, clears and rare resets
        for (int ph = 0; ph < 12; ph++) begin
            int dens;
            int rdy;
            dens = $urandom_range(10, 90);
            rdy  = $urandom_range(0, 100);
            for (int i = 0; i < 250; i++) begin
                for (int r = 0; r < 4; r++) ovalid[r] = ($urandom_range(0, 99) < dens);
                odata   = {$urandom, $urandom};
                m_ready = ($urandom_range(0, 99) < rdy);
                clr_err = ($urandom_range(0, 99) < 5);
                rstn    = ($urandom_range(0, 999) >= 3);
                tick();
            end
        end
        rstn    = 1'b1;
        ovalid  = 4'b0000;
        clr_err = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
